// File: rtl/bsg_link_ds_gather.sv
// bsg_link_ds_gather: io-domain downstream gather stage.
// Collects NUM_CH_P*CH_WIDTH_P-bit io beats into WIDTH_P-bit core words. Beat 0
// lands in the least significant bits. Finished words go into a small circular
// FIFO, and the block returns credits upstream by toggling token_o once for every
// TOKEN_DECIMATION_P words the core consumes.
// Optional build macro BSG_LINK_DS_GATHER_STATS_EN adds the words_recv_o and
// words_dropped_o counters.
//
// Handshake: valid_o is asserted whenever the FIFO holds a word, and data_o shows
// that head word. When yumi_i is high in a cycle where valid_o is high, the head
// is consumed at the next clock edge. yumi_i must stay low while valid_o is low.
// The io side has no back-pressure. A word that completes while the FIFO is full,
// with no dequeue in the same cycle, is discarded and sets the sticky overflow_o.
module bsg_link_ds_gather #(
  parameter int WIDTH_P            = 64,
  parameter int NUM_CH_P           = 2,
  parameter int CH_WIDTH_P         = 8,
  parameter int FIFO_DEPTH_P       = 4,
  parameter int TOKEN_DECIMATION_P = 2
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           io_valid_i,
  input  logic [NUM_CH_P*CH_WIDTH_P-1:0] io_data_i,
  output logic                           valid_o,
  output logic [WIDTH_P-1:0]             data_o,
  input  logic                           yumi_i,
  output logic                           token_o,
  output logic                           overflow_o
`ifdef BSG_LINK_DS_GATHER_STATS_EN
  ,
  output logic [31:0]                    words_recv_o,
  output logic [15:0]                    words_dropped_o
`endif
);

  localparam int BEAT_W = NUM_CH_P * CH_WIDTH_P;
  localparam int BEATS  = WIDTH_P / BEAT_W;
  localparam int CNT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int PTR_W  = $clog2(FIFO_DEPTH_P);
  localparam int DEC_W  = (TOKEN_DECIMATION_P > 1) ? $clog2(TOKEN_DECIMATION_P) : 1;

  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);
  localparam logic [PTR_W:0]   DEPTH_C   = (PTR_W + 1)'(FIFO_DEPTH_P);
  localparam logic [DEC_W-1:0] LAST_DEC  = DEC_W'(TOKEN_DECIMATION_P - 1);

  logic [CNT_W-1:0]   r_beat_cnt;
  logic [WIDTH_P-1:0] r_partial;
  logic [WIDTH_P-1:0] r_mem [FIFO_DEPTH_P];
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W:0]     r_count;
  logic [DEC_W-1:0]   r_dec_cnt;
  logic               r_token;
  logic               r_overflow;

  logic [WIDTH_P-1:0] w_word;
  logic               w_last_beat;
  logic               w_full;
  logic               w_deq;
  logic               w_push;
  logic               w_drop;

  // Merge the current beat into its slot of the partial word. The result is the
  // complete word on the last beat.
  always_comb begin
    w_word = r_partial;
    for (int b = 0; b < BEATS; b++) begin
      if (r_beat_cnt == CNT_W'(b)) begin
        w_word[b*BEAT_W +: BEAT_W] = io_data_i;
      end
    end
  end

  // A push that arrives while the FIFO is full is still accepted when the head
  // leaves in the same cycle.
  always_comb begin
    w_last_beat = io_valid_i && (r_beat_cnt == LAST_BEAT);
    w_full      = (r_count == DEPTH_C);
    w_deq       = yumi_i && (r_count != '0);
    w_push      = w_last_beat && (!w_full || w_deq);
    w_drop      = w_last_beat && w_full && !w_deq;
  end

  // The beat counter and the partial word advance only on io beats.
  // The counter wraps even when the word is dropped, so word alignment is kept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_beat_cnt <= '0;
      r_partial  <= '0;
    end else if (io_valid_i) begin
      r_partial  <= w_word;
      r_beat_cnt <= (r_beat_cnt == LAST_BEAT) ? '0 : r_beat_cnt + CNT_W'(1);
    end
  end

  // Word storage. It is cleared on reset so that the stale head shows as zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH_P; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_push) begin
      r_mem[r_wr_ptr] <= w_word;
    end
  end

  // Circular-buffer pointers and the occupancy count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_deq)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_deq})
        2'b10:   r_count <= r_count + (PTR_W + 1)'(1);
        2'b01:   r_count <= r_count - (PTR_W + 1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Credit return: the token toggles once every TOKEN_DECIMATION_P dequeues.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_dec_cnt <= '0;
      r_token   <= 1'b0;
    end else if (w_deq) begin
      if (r_dec_cnt == LAST_DEC) begin
        r_dec_cnt <= '0;
        r_token   <= ~r_token;
      end else begin
        r_dec_cnt <= r_dec_cnt + DEC_W'(1);
      end
    end
  end

  // Sticky overflow flag, set when a completed word is discarded.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_overflow <= 1'b0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
    end
  end

`ifdef BSG_LINK_DS_GATHER_STATS_EN
  logic [31:0] r_words_recv;
  logic [15:0] r_words_dropped;

  // Statistics: the accepted-word count wraps; the dropped-word count saturates.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_words_recv    <= '0;
      r_words_dropped <= '0;
    end else begin
      if (w_push) r_words_recv <= r_words_recv + 32'd1;
      if (w_drop && (r_words_dropped != 16'hFFFF)) begin
        r_words_dropped <= r_words_dropped + 16'd1;
      end
    end
  end

  assign words_recv_o    = r_words_recv;
  assign words_dropped_o = r_words_dropped;
`endif

  assign valid_o    = (r_count != '0);
  assign data_o     = r_mem[r_rd_ptr];
  assign token_o    = r_token;
  assign overflow_o = r_overflow;

  // The core must never consume from an empty FIFO.
  yumi_when_empty: assert property (@(posedge clk) disable iff (rst) !(yumi_i && !valid_o))
    else $error("yumi_i asserted while valid_o=0");

endmodule

// File: tb/tb_bsg_link_ds_gather.sv
// Directed and randomized bench for bsg_link_ds_gather. A reference model built
// from a queue of words checks every cycle. The model assembles each word by
// shifting beats into place, and computes the expected token from the total
// number of dequeues.
module tb_bsg_link_ds_gather;

  localparam int WIDTH = 64;
  localparam int BW    = 16;
  localparam int BEATS = WIDTH / BW;
  localparam int DEPTH = 4;
  localparam int TOK   = 2;

  logic             clk;
  logic             rst;
  logic             io_valid_i;
  logic [BW-1:0]    io_data_i;
  logic             valid_o;
  logic [WIDTH-1:0] data_o;
  logic             yumi_i;
  logic             token_o;
  logic             overflow_o;
`ifdef BSG_LINK_DS_GATHER_STATS_EN
  logic [31:0]      words_recv_o;
  logic [15:0]      words_dropped_o;
`endif

  bsg_link_ds_gather dut (
    .clk        (clk),
    .rst        (rst),
    .io_valid_i (io_valid_i),
    .io_data_i  (io_data_i),
    .valid_o    (valid_o),
    .data_o     (data_o),
    .yumi_i     (yumi_i),
    .token_o    (token_o),
    .overflow_o (overflow_o)
`ifdef BSG_LINK_DS_GATHER_STATS_EN
    ,
    .words_recv_o    (words_recv_o),
    .words_dropped_o (words_dropped_o)
`endif
  );

  // Clock and reset initial state.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard and reference model state.
  logic [WIDTH-1:0] exp_q[$];
  logic [WIDTH-1:0] m_part;
  int               m_beat;
  int               m_yumis;
  logic             m_ovf;
  int               m_recv;
  int               m_drop;

  int n_total = 0;
  int n_pass  = 0;

  task automatic chk(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic check_outputs();
    chk("valid_o", WIDTH'(valid_o), WIDTH'(exp_q.size() > 0));
    if (exp_q.size() > 0) chk("data_o", data_o, exp_q[0]);
    chk("token_o", WIDTH'(token_o), WIDTH'((m_yumis / TOK) % 2));
    chk("overflow_o", WIDTH'(overflow_o), WIDTH'(m_ovf));
`ifdef BSG_LINK_DS_GATHER_STATS_EN
    chk("words_recv_o", WIDTH'(words_recv_o), WIDTH'(m_recv));
    chk("words_dropped_o", WIDTH'(words_dropped_o), WIDTH'(m_drop));
`endif
  endtask

  // Asynchronous reset: the outputs must clear without waiting for a clock edge.
  task automatic do_reset();
    rst = 1'b1;
    io_valid_i = 1'b0;
    io_data_i  = '0;
    yumi_i     = 1'b0;
    exp_q.delete();
    m_part = '0; m_beat = 0; m_yumis = 0; m_ovf = 1'b0; m_recv = 0; m_drop = 0;
    #1;
    chk("rst_valid_o", WIDTH'(valid_o), '0);
    chk("rst_data_o", data_o, '0);
    chk("rst_token_o", WIDTH'(token_o), '0);
    chk("rst_overflow_o", WIDTH'(overflow_o), '0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // One clock cycle. Inputs change at posedge+1; the model updates at the edge;
  // outputs are checked at posedge+1. yumi is suppressed when the model is empty.
  task automatic step(input logic v, input logic [BW-1:0] d, input logic y);
    logic deq;
    logic was_full;
    deq = y && (exp_q.size() > 0);
    io_valid_i = v;
    io_data_i  = d;
    yumi_i     = deq;
    @(posedge clk);
    was_full = (exp_q.size() == DEPTH);
    if (deq) begin
      exp_q.delete(0);
      m_yumis++;
    end
    if (v) begin
      m_part = m_part | (WIDTH'(d) << (BW * m_beat));
      m_beat++;
      if (m_beat == BEATS) begin
        if (!was_full || deq) begin
          exp_q.push_back(m_part);
          m_recv++;
        end else begin
          m_ovf = 1'b1;
          if (m_drop < 65535) m_drop++;
        end
        m_part = '0;
        m_beat = 0;
      end
    end
    #1;
    io_valid_i = 1'b0;
    yumi_i     = 1'b0;
    check_outputs();
  endtask

  task automatic send_word(input logic [WIDTH-1:0] w, input int max_gap);
    for (int b = 0; b < BEATS; b++) begin
      step(1'b1, w[b*BW +: BW], 1'b0);
      if (max_gap > 0 && b < BEATS - 1) begin
        repeat ($urandom_range(1, max_gap)) step(1'b0, '0, 1'b0);
      end
    end
  endtask

  function automatic logic [WIDTH-1:0] rand_word();
    return {$urandom(), $urandom()};
  endfunction

  initial begin
    logic [WIDTH-1:0] w;

    // Reset and the directed first word.
    do_reset();
    w = 64'h7766554433221100;
    send_word(w, 0);
    chk("first_word", data_o, 64'h7766554433221100);
    step(1'b0, '0, 1'b1);
    chk("first_yumi_token", WIDTH'(token_o), '0);

    // The second dequeue toggles the token; two more bring it back to 0.
    send_word(rand_word(), 0);
    step(1'b0, '0, 1'b1);
    chk("token_after_2", WIDTH'(token_o), 1);
    for (int i = 0; i < 2; i++) begin
      send_word(rand_word(), 0);
      step(1'b0, '0, 1'b1);
    end
    chk("token_after_4", WIDTH'(token_o), 0);

    // Beats separated by idle gaps.
    for (int i = 0; i < 3; i++) begin
      send_word(rand_word(), 3);
      step(1'b0, '0, 1'b1);
    end

    // Overflow: five words with no dequeue, then drain in order.
    for (int i = 0; i < 5; i++) send_word(rand_word(), 0);
    chk("overflow_set", WIDTH'(overflow_o), 1);
    for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b1);
    chk("overflow_sticky", WIDTH'(overflow_o), 1);
    chk("drained_empty", WIDTH'(valid_o), 0);

    // A push while full is accepted when a yumi arrives in the same cycle.
    do_reset();
    for (int i = 0; i < 4; i++) send_word(rand_word(), 0);
    w = rand_word();
    for (int b = 0; b < BEATS - 1; b++) step(1'b1, w[b*BW +: BW], 1'b0);
    step(1'b1, w[(BEATS-1)*BW +: BW], 1'b1);
    chk("full_push_no_ovf", WIDTH'(overflow_o), 0);
    for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b1);
    chk("full_push_drained", WIDTH'(valid_o), 0);

    // Reset in the middle of a word, then check that a new word is aligned.
    do_reset();
    step(1'b1, 16'hAAAA, 1'b0);
    step(1'b1, 16'hBBBB, 1'b0);
    do_reset();
    w = 64'h0123456789ABCDEF;
    send_word(w, 0);
    chk("post_reset_word", data_o, 64'h0123456789ABCDEF);
`ifdef BSG_LINK_DS_GATHER_STATS_EN
    chk("post_reset_recv", WIDTH'(words_recv_o), 1);
`endif

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 3) != 0), BW'($urandom()), 1'($urandom_range(0, 2) == 0));
    end
    for (int i = 0; i < 8; i++) step(1'b0, '0, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
